// File: rtl/conv_2d_pipe.sv
// conv_2d_pipe: pipelined KxK signed convolution with double-buffered coefficients, rounding, saturation and post-op
module conv_2d_pipe #(
  parameter int K          = 3,
  parameter int NB_DATA    = 8,
  parameter int NBF_DATA   = 7,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [K*K*NB_DATA-1:0]       i_data,
  input  logic [1:0]                   i_mode,
  input  logic                         i_coef_we,
  input  logic [$clog2(K*K)-1:0]       i_coef_addr,
  input  logic [NB_COEFF-1:0]          i_coef_data,
  input  logic                         i_coef_commit,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [NB_OUTPUT-1:0]         o_pixel,
  output logic                         o_sat
);
  localparam int T        = K * K;
  localparam int NB_PROD  = NB_DATA + NB_COEFF;
  localparam int NBF_PROD = NBF_DATA + NBF_COEFF;
  localparam int NB_ROW   = NB_PROD + $clog2(K);
  localparam int NB_ADD   = NB_PROD + $clog2(T);
  localparam int NB_POST  = NB_ADD + 1;
  localparam int NB_RND   = NB_ADD + 2;
  localparam int SH       = NBF_PROD - NBF_OUTPUT;
  localparam logic signed [NB_RND-1:0] RND   = {{(NB_RND-1){1'b0}}, 1'b1} << (SH - 1);
  localparam logic signed [NB_RND-1:0] MAX_O = NB_RND'($signed({1'b0, {(NB_OUTPUT-1){1'b1}}}));
  localparam logic signed [NB_RND-1:0] MIN_O = NB_RND'($signed({1'b1, {(NB_OUTPUT-1){1'b0}}}));

  logic signed [NB_COEFF-1:0] shadow_q [T];
  logic signed [NB_COEFF-1:0] shadow_d [T];
  logic signed [NB_COEFF-1:0] active_q [T];
  logic signed [NB_COEFF-1:0] active_d [T];
  logic signed [NB_PROD-1:0]  prod_q [T];
  logic signed [NB_PROD-1:0]  prod_d [T];
  logic signed [NB_ROW-1:0]   row_q [K];
  logic signed [NB_ROW-1:0]   row_d [K];
  logic                       v1_q, v1_d, v2_q, v2_d;
  logic [1:0]                 mode1_q, mode1_d, mode2_q, mode2_d;
  logic                       o_valid_q, o_valid_d, o_sat_q, o_sat_d;
  logic [NB_OUTPUT-1:0]       o_pixel_q, o_pixel_d;
  logic signed [NB_ADD-1:0]   sum;
  logic signed [NB_POST-1:0]  post;
  logic signed [NB_RND-1:0]   rnd;
  logic                       en;

  assign en      = i_ready;
  assign o_ready = i_ready;
  assign o_valid = o_valid_q;
  assign o_pixel = o_pixel_q;
  assign o_sat   = o_sat_q;

  // commit copies the pre-write shadow, so a same-cycle write lands in shadow only
  always_comb begin
    shadow_d = shadow_q;
    if (i_coef_we && int'(i_coef_addr) < T) shadow_d[i_coef_addr] = i_coef_data;
    active_d = active_q;
    if (i_coef_commit) active_d = shadow_q;
  end

  always_comb begin
    v1_d    = en ? i_valid : v1_q;
    mode1_d = en ? i_mode : mode1_q;
    for (int t = 0; t < T; t++)
      prod_d[t] = en ? NB_PROD'($signed(i_data[(T-1-t)*NB_DATA +: NB_DATA])) * NB_PROD'(active_q[t])
                     : prod_q[t];
  end

  always_comb begin
    v2_d    = en ? v1_q : v2_q;
    mode2_d = en ? mode1_q : mode2_q;
    for (int r = 0; r < K; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < K; c++) row_d[r] = row_d[r] + NB_ROW'(prod_q[r*K+c]);
      if (!en) row_d[r] = row_q[r];
    end
  end

  // post-op is widened by one bit so |most negative| stays representable
  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++) sum = sum + NB_ADD'(row_q[r]);
    post = NB_POST'(sum);
    if (mode2_q == 2'd1 && sum[NB_ADD-1]) post = '0;
    if (mode2_q == 2'd2 && sum[NB_ADD-1]) post = -post;
    rnd       = (NB_RND'(post) + RND) >>> SH;
    o_valid_d = en ? v2_q : o_valid_q;
    o_sat_d   = en ? (rnd > MAX_O || rnd < MIN_O) : o_sat_q;
    o_pixel_d = en ? (rnd > MAX_O ? MAX_O[NB_OUTPUT-1:0] :
                      rnd < MIN_O ? MIN_O[NB_OUTPUT-1:0] : rnd[NB_OUTPUT-1:0]) : o_pixel_q;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      prod_q    <= '{default: '0};
      row_q     <= '{default: '0};
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      mode1_q   <= 2'd0;
      mode2_q   <= 2'd0;
      o_valid_q <= 1'b0;
      o_sat_q   <= 1'b0;
      o_pixel_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      prod_q    <= prod_d;
      row_q     <= row_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      mode1_q   <= mode1_d;
      mode2_q   <= mode2_d;
      o_valid_q <= o_valid_d;
      o_sat_q   <= o_sat_d;
      o_pixel_q <= o_pixel_d;
    end
  end
endmodule

// File: tb/tb_conv_2d_pipe.sv
// tb_conv_2d_pipe: scoreboard bench for conv_2d_pipe against an arithmetic reference model
module tb_conv_2d_pipe;
  localparam int K = 3, T = K * K, NBD = 8, NBC = 8, NBO = 8, SH = 7 + 7 - 7;
  logic clk = 0, i_rst = 1, i_valid = 0, i_ready = 1, i_coef_we = 0, i_coef_commit = 0;
  logic o_ready, o_valid, o_sat;
  logic [T*NBD-1:0] i_data = '0;
  logic [1:0] i_mode = 2'd0;
  logic [3:0] i_coef_addr = 4'd0;
  logic [NBC-1:0] i_coef_data = '0;
  logic [NBO-1:0] o_pixel;
  int shadow [T];
  int active [T];
  logic [8:0] exp_q [$];
  logic [8:0] e;
  int checks = 0, errors = 0;
  logic hold_v = 0;
  logic [NBO-1:0] hold_pix;

  conv_2d_pipe dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_mode(i_mode), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data), .i_coef_commit(i_coef_commit), .o_valid(o_valid),
    .i_ready(i_ready), .o_pixel(o_pixel), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // result = sat(round(post(sum(data*coef)))), returned as {sat, pixel}
  function automatic logic [8:0] model(logic [T*NBD-1:0] d, logic [1:0] m);
    longint s = 0;
    longint v, hi, lo;
    logic [NBO-1:0] p;
    hi = (longint'(1) <<< (NBO - 1)) - 1;
    lo = -(longint'(1) <<< (NBO - 1));
    for (int t = 0; t < T; t++) s += longint'($signed(d[(T-1-t)*NBD +: NBD])) * active[t];
    if (m == 2'd1 && s < 0) s = 0;
    if (m == 2'd2 && s < 0) s = -s;
    v = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    else begin
      p = NBO'(v);
      return {1'b0, p};
    end
    p = NBO'(v);
    return {1'b1, p};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (i_rst) begin
      exp_q.delete();
      foreach (shadow[t]) begin shadow[t] = 0; active[t] = 0; end
    end else begin
      if (i_valid && i_ready) exp_q.push_back(model(i_data, i_mode));
      if (i_coef_commit) active = shadow;
      if (i_coef_we && i_coef_addr < T) shadow[i_coef_addr] = $signed(i_coef_data);
    end
    #1;
  endtask

  function automatic logic [T*NBD-1:0] win(logic [7:0] centre, logic [7:0] other);
    logic [T*NBD-1:0] w;
    for (int t = 0; t < T; t++) w[(T-1-t)*NBD +: NBD] = (t == T / 2) ? centre : other;
    return w;
  endfunction

  function automatic logic [T*NBD-1:0] rnd_win();
    logic [T*NBD-1:0] w;
    for (int t = 0; t < T; t++) w[t*NBD +: NBD] = NBD'($urandom);
    return w;
  endfunction

  task automatic wr(int a, logic [7:0] v);
    i_coef_we = 1; i_coef_addr = 4'(a); i_coef_data = v;
    cycle();
    i_coef_we = 0;
  endtask

  task automatic load_all(logic [7:0] v, logic [7:0] centre);
    for (int t = 0; t < T; t++) wr(t, (t == T / 2) ? centre : v);
    i_coef_commit = 1;
    cycle();
    i_coef_commit = 0;
  endtask

  task automatic send(logic [T*NBD-1:0] d, logic [1:0] m);
    logic ok;
    i_valid = 1; i_data = d; i_mode = m;
    for (int n = 0; n < 50; n++) begin
      ok = i_ready;
      cycle();
      if (ok) break;
    end
    i_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 0; i_ready = 1; i_coef_we = 0; i_coef_commit = 0;
    while (exp_q.size() != 0 && n < 40) begin cycle(); n++; end
    cycle();
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic one(string name, logic [T*NBD-1:0] d, logic [1:0] m, logic [8:0] exp);
    send(d, m);
    cycle();
    cycle();
    chk({name, "_valid"}, o_valid, 1);
    chk({name, "_result"}, {o_sat, o_pixel}, exp);
    drain();
  endtask

  always @(negedge clk) begin
    if (hold_v) begin
      chk("stall_hold_valid", o_valid, 1);
      chk("stall_hold_pixel", o_pixel, hold_pix);
    end
    hold_v = 0;
    if (!i_rst && o_valid) begin
      if (!i_ready) begin
        hold_v = 1;
        hold_pix = o_pixel;
      end else if (exp_q.size() == 0) chk("unexpected_output", o_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("scoreboard", {o_sat, o_pixel}, e);
      end
    end
  end

  initial begin
    repeat (2) cycle();
    i_rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_pixel", o_pixel, 0);
    chk("rst_sat", o_sat, 0);
    i_ready = 0;
    #1 chk("ready_follow_lo", o_ready, 0);
    i_ready = 1;
    #1 chk("ready_follow_hi", o_ready, 1);
    // half-scale centre tap and exact 3-edge latency
    load_all(8'h00, 8'h40);
    i_valid = 1; i_data = win(8'h40, 8'h40); i_mode = 2'd0;
    cycle();
    i_valid = 0;
    chk("lat_edge0", o_valid, 0);
    cycle();
    chk("lat_edge1", o_valid, 0);
    cycle();
    chk("lat_edge2", o_valid, 1);
    chk("half_scale", {o_sat, o_pixel}, 9'h020);
    drain();
    // rounding half-up
    load_all(8'h00, 8'h01);
    one("round_up", win(8'h40, 8'h55), 2'd0, 9'h001);
    one("round_down", win(8'h3f, 8'h55), 2'd0, 9'h000);
    // saturation and post-ops
    load_all(8'h7f, 8'h7f);
    one("sat_pos", win(8'h7f, 8'h7f), 2'd0, 9'h17f);
    load_all(8'h80, 8'h80);
    one("sat_neg", win(8'h7f, 8'h7f), 2'd0, 9'h180);
    one("relu", win(8'h7f, 8'h7f), 2'd1, 9'h000);
    one("abs_sat", win(8'h7f, 8'h7f), 2'd2, 9'h17f);
    one("mode3_none", win(8'h7f, 8'h7f), 2'd3, 9'h180);
    // back-to-back with a 2-cycle stall
    load_all(8'h00, 8'h7f);
    send(win(8'h10, 8'h00), 2'd0);
    send(win(8'h20, 8'h00), 2'd0);
    send(win(8'hd0, 8'h00), 2'd0);
    i_valid = 1; i_data = win(8'h40, 8'h00); i_ready = 0;
    cycle();
    cycle();
    i_ready = 1;
    send(win(8'h40, 8'h00), 2'd0);
    send(win(8'h90, 8'h00), 2'd2);
    drain();
    // bank swap while streaming, commit coinciding with a tap-0 write
    i_valid = 1; i_mode = 2'd0;
    for (int t = 0; t < T; t++) begin
      i_data = rnd_win(); i_coef_we = 1; i_coef_addr = 4'(t); i_coef_data = 8'($urandom_range(0, 63));
      cycle();
    end
    i_data = rnd_win(); i_coef_addr = 4'd0; i_coef_data = 8'hc0; i_coef_commit = 1;
    cycle();
    i_coef_we = 0; i_coef_commit = 0;
    repeat (4) begin i_data = rnd_win(); cycle(); end
    i_coef_commit = 1; i_data = rnd_win();
    cycle();
    i_coef_commit = 0;
    repeat (4) begin i_data = rnd_win(); cycle(); end
    drain();
    // reset with three beats in flight
    load_all(8'h22, 8'h7f);
    send(rnd_win(), 2'd0);
    send(rnd_win(), 2'd0);
    send(rnd_win(), 2'd0);
    i_rst = 1;
    cycle();
    chk("midrst_valid", o_valid, 0);
    chk("midrst_pixel", o_pixel, 0);
    chk("midrst_sat", o_sat, 0);
    i_rst = 0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("post_rst_no_stale", o_valid, 0);
    end
    one("cleared_coefs", win(8'h7f, 8'h7f), 2'd0, 9'h000);
    // randomized traffic, writes and commits, including commits under stall
    for (int n = 0; n < 400; n++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 4) != 0;
      i_data = rnd_win();
      i_mode = 2'($urandom);
      i_coef_we = $urandom_range(0, 3) == 0;
      i_coef_addr = 4'($urandom);
      i_coef_data = 8'($urandom);
      i_coef_commit = $urandom_range(0, 15) == 0;
      cycle();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_2d_pipe.md
Name: conv_2d_pipe

Overview:
Parametrised, pipelined KxK signed 2D convolution engine for streaming image windows. It takes a full KxK window per beat, multiplies it by a double-buffered coefficient bank and reduces the products through a registered adder tree. The result is rounded and saturated to a configurable Q-format, and an optional ReLU or absolute-value post-op can be applied. Valid/ready handshake with whole-pipeline stall; sits between the line-buffer window generator and the pixel writer.

Parameters:
K, 3, kernel side length; taps T = K*K; odd, 3..7
NB_DATA, 8, window sample width, signed
NBF_DATA, 7, fractional bits of sample
NB_COEFF, 8, coefficient width, signed
NBF_COEFF, 7, fractional bits of coefficient
NB_OUTPUT, 8, output pixel width, signed
NBF_OUTPUT, 7, fractional bits of output; must be < NBF_DATA+NBF_COEFF

Ports:
clk  in  1  clock
i_rst  in  1  reset: synchronous, active-high
i_valid  in  1  window beat valid
o_ready  out  1  engine can accept a beat; equals i_ready
i_data  in  T*NB_DATA  window, row-major, tap 0 (top-left) in MSBs
i_mode  in  2  post-op, sampled with the beat: 0 none, 1 ReLU, 2 abs, 3 = none
i_coef_we  in  1  shadow coefficient write strobe
i_coef_addr  in  clog2(T)  tap index, 0 = top-left
i_coef_data  in  NB_COEFF  coefficient value
i_coef_commit  in  1  copy shadow bank into active bank
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_pixel  out  NB_OUTPUT  convolution result
o_sat  out  1  result was clipped; qualified by o_valid

Behaviour:
- Reset: all pipeline valids = 0; o_valid = 0, o_pixel = 0, o_sat = 0; shadow and active banks cleared to 0. Reset asserted mid-stream drops all in-flight beats.
- Advance: the enable is en = i_ready. When en = 0, every stage register holds, and o_valid/o_pixel/o_sat stay stable. A beat is accepted when i_valid && o_ready.
- Latency: exactly 3 enabled cycles from accept to o_valid. Full throughput is 1 beat/cycle while i_ready = 1. Bubbles (i_valid = 0) propagate as valid = 0.
- Stage 1: registers T products, each prod[t] = data[t]*active[t] with signed width NB_PROD = NB_DATA+NB_COEFF and fractional bits NBF_PROD = NBF_DATA+NBF_COEFF. i_mode is registered alongside.
- Stage 2: registers K row sums, each sign-extended to NB_PROD+clog2(K).
- Stage 3: total sum at width NB_ADD = NB_PROD+clog2(T) (no internal overflow possible), followed by post-processing, registered into o_pixel/o_sat.
- Post-processing order:
  - (a) mode 1: negative sum -> 0; mode 2: sum -> |sum|, computed at NB_ADD+1 bits so -max is safe.
  - (b) round half-up: add 1 << (SH-1), where SH = NBF_PROD-NBF_OUTPUT, then arithmetic shift right by SH.
  - (c) saturate to NB_OUTPUT signed. Above max -> 0111..1, below min -> 1000..0, and o_sat = 1; otherwise o_sat = 0.
- Coefficients:
  - i_coef_we writes shadow[i_coef_addr] on the clock edge; addr >= T is ignored.
  - i_coef_commit copies the whole shadow bank to the active bank in one cycle. The copy uses the shadow contents before any same-cycle write, so a write in the commit cycle lands in shadow only.
  - Stage 1 uses the active bank value present at the accept edge. Beats accepted on or before the commit edge use the old bank; beats accepted after it use the new bank. Commit is honoured even when en = 0.
- Stage valids advance only on en.

Test Plan:
1. Half-scale centre tap: commit active bank with coef[4] = 0x40, all other taps 0; i_data all taps 0x40, mode 0 -> after 3 cycles o_valid = 1, o_pixel = 0x20, o_sat = 0.
2. Rounding: coef[4] = 0x01; data centre 0x40 -> o_pixel = 0x01 (0.5 LSB rounds up). Data centre 0x3F -> o_pixel = 0x00.
3. Saturation and modes: all coef 0x7F, all data 0x7F -> o_pixel = 0x7F, o_sat = 1. All coef 0x80, data 0x7F: mode 0 -> o_pixel = 0x80, o_sat = 1; mode 1 -> o_pixel = 0x00, o_sat = 0; mode 2 -> o_pixel = 0x7F, o_sat = 1.
4. Back-to-back and stall: 5 consecutive beats with distinct centre data; drop i_ready for 2 cycles mid-stream. Required: outputs appear in order with no loss or duplication, and o_pixel is held during the stall.
5. Bank swap: stream beats continuously while writing a new shadow bank, then assert commit together with a write to tap 0. Required: results switch bank exactly at the beat after the commit edge; the tap-0 write appears only after a second commit.
6. Reset mid-stream: assert i_rst with 3 beats in flight -> next cycle o_valid = 0 and o_pixel = 0, with no stale results afterwards; coefficients read as 0 until reloaded and committed.
